mdl_dleval_gen: RTL

//  Parametrised data-length evaluator for the bubble transfer path. Loads a bootloader or page length,

---
 rtl/mdl_dleval_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mdl_dleval_gen.sv
// Data-length evaluator: counts a bootloader/page length down by lane width, then sequences
// byte-boundary wait, supplementary-start pulse and supplementary completion. Fully registered.
module mdl_dleval_gen #(
    parameter int CNT_W    = 12,
    parameter int BOOT_LEN = 480
) (
    input  logic             i_MCLK,
    input  logic             i_SYS_RST_n,
    input  logic             i_CLK2M_PCEN_n,
    input  logic             i_TST,
    input  logic             i_UMODE_n,
    input  logic [1:0]       i_LANE_SEL,
    input  logic [CNT_W-1:0] i_PAGE_LEN,
    input  logic             i_XFER_START,
    input  logic             i_SLOT_STB,
    input  logic             i_BYTEACQ_DONE,
    input  logic             i_SUPBD_END_n,
    input  logic             i_ABORT,
    output logic             o_SUPBD_START_n,
    output logic             o_EFFBD_DONE,
    output logic             o_BUSY,
    output logic [CNT_W-1:0] o_REMAIN,
    output logic             o_LEN_ERR,
    output logic             o_XFER_DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_WAIT  = 2'd2,
        S_SUPBD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BOOT_LEN_C = CNT_W'(BOOT_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [1:0]       lane_q, lane_d;
    logic             err_q, err_d;
    logic             sup_n_q, sup_n_d;
    logic             effbd_q, effbd_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] len_sel;
    logic [CNT_W-1:0] rem_nx;

    assign step    = {{(CNT_W-1){1'b0}}, 1'b1} << lane_q;
    assign len_sel = i_UMODE_n ? BOOT_LEN_C : i_PAGE_LEN;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        lane_d   = lane_q;
        err_d    = err_q;
        sup_n_d  = sup_n_q;
        effbd_d  = effbd_q;
        done_d   = done_q;
        rem_nx   = remain_q;

        if (!i_CLK2M_PCEN_n) begin
            sup_n_d = 1'b1;
            done_d  = 1'b0;
            if (i_ABORT) begin
                state_d  = S_IDLE;
                remain_d = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_XFER_START) begin
                            remain_d = len_sel;
                            lane_d   = i_LANE_SEL;
                            err_d    = 1'b0;
                            state_d  = (len_sel == '0) ? S_WAIT : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (i_SLOT_STB) begin
                            // A short final slot saturates at zero and flags a ragged length.
                            if (i_TST) begin
                                rem_nx = '0;
                            end else if (remain_q < step) begin
                                rem_nx = '0;
                                err_d  = 1'b1;
                            end else begin
                                rem_nx = remain_q - step;
                            end
                            remain_d = rem_nx;
                            if (rem_nx == '0) begin
                                if (i_BYTEACQ_DONE) begin
                                    state_d = S_SUPBD;
                                    sup_n_d = 1'b0;
                                end else begin
                                    state_d = S_WAIT;
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        if (i_BYTEACQ_DONE) begin
                            state_d = S_SUPBD;
                            sup_n_d = 1'b0;
                        end
                    end
                    S_SUPBD: begin
                        // sup_n_q low marks the entry cycle, where the end strobe is not yet honoured.
                        if (sup_n_q && !i_SUPBD_END_n) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            effbd_d = (state_d == S_WAIT) || (state_d == S_SUPBD);
        end
    end

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            lane_q   <= 2'd0;
            err_q    <= 1'b0;
            sup_n_q  <= 1'b1;
            effbd_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            lane_q   <= lane_d;
            err_q    <= err_d;
            sup_n_q  <= sup_n_d;
            effbd_q  <= effbd_d;
            done_q   <= done_d;
        end
    end

    assign o_SUPBD_START_n = sup_n_q;
    assign o_EFFBD_DONE    = effbd_q;
    assign o_BUSY          = (state_q != S_IDLE);
    assign o_REMAIN        = remain_q;
    assign o_LEN_ERR       = err_q;
    assign o_XFER_DONE     = done_q;

endmodule
